// File: rtl/issue_rat_freelist_mp_pkg.sv
// Shared constants, id types and ring arithmetic for the issue-stage RAT free list.
package issue_pkg;
  localparam int unsigned PRF_W      = 6;
  localparam int unsigned FGR_W      = 3;
  localparam int unsigned ARCH_COUNT = 32;

  typedef logic [PRF_W-1:0] prf_id_t;
  typedef logic [FGR_W-1:0] fgr_id_t;

  // (a - b) modulo 2^ptr_w: how far a lies ahead of b on the pointer ring.
  function automatic int unsigned ring_dist(input int unsigned a, input int unsigned b,
                                            input int unsigned ptr_w);
    int unsigned mask;
    mask = (ptr_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ptr_w) - 32'd1);
    return (a - b) & mask;
  endfunction
endpackage

// File: rtl/issue_rat_freelist_mp_ckpt.sv
// Per-FGR read-pointer checkpoints: creation, commit, abandon with younger-group clear, oldest live head.
module issue_rat_freelist_ckpt #(
  parameter int unsigned PRF_W     = issue_pkg::PRF_W,
  parameter int unsigned FGR_COUNT = 8,
  parameter int unsigned FGR_W     = issue_pkg::FGR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PRF_W:0]   head,
  input  logic             acq_fire,
  input  logic             acq_spec,
  input  logic [FGR_W-1:0] acq_fgr,
  input  logic             commit_valid,
  input  logic [FGR_W-1:0] commit_fgr,
  input  logic             abandon_valid,
  input  logic [FGR_W-1:0] abandon_fgr,
  output logic             restore_valid,
  output logic [PRF_W:0]   restore_ptr,
  output logic [PRF_W:0]   oldest_ptr
);
  localparam int unsigned PTR_W = PRF_W + 1;

  logic [PRF_W:0]       ckpt_head [FGR_COUNT];
  logic [FGR_COUNT-1:0] ckpt_valid;
  logic [FGR_COUNT-1:0] valid_next;
  logic                 create;
  int unsigned          best_dist;

  assign restore_valid = abandon_valid && ckpt_valid[abandon_fgr];
  assign restore_ptr   = ckpt_head[abandon_fgr];

  // Commit clears first so a same-cycle speculative acquire on that FGR re-arms it.
  always_comb begin
    valid_next = ckpt_valid;
    create     = 1'b0;
    if (commit_valid)
      valid_next[commit_fgr] = 1'b0;
    if (acq_fire && acq_spec && !valid_next[acq_fgr]) begin
      create              = 1'b1;
      valid_next[acq_fgr] = 1'b1;
    end
    if (restore_valid) begin
      for (int unsigned g = 0; g < FGR_COUNT; g++) begin
        if (issue_pkg::ring_dist(32'(ckpt_head[g]), 32'(restore_ptr), PTR_W) <
            issue_pkg::ring_dist(32'(head), 32'(restore_ptr), PTR_W))
          valid_next[g] = 1'b0;
      end
      valid_next[abandon_fgr] = 1'b0;
    end
  end

  // The oldest live checkpoint is the one furthest behind the current head.
  always_comb begin
    oldest_ptr = head;
    best_dist  = 0;
    for (int unsigned g = 0; g < FGR_COUNT; g++) begin
      if (ckpt_valid[g] &&
          issue_pkg::ring_dist(32'(head), 32'(ckpt_head[g]), PTR_W) > best_dist) begin
        best_dist  = issue_pkg::ring_dist(32'(head), 32'(ckpt_head[g]), PTR_W);
        oldest_ptr = ckpt_head[g];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ckpt_valid <= '0;
      for (int unsigned g = 0; g < FGR_COUNT; g++)
        ckpt_head[g] <= '0;
    end else begin
      ckpt_valid <= valid_next;
      if (create)
        ckpt_head[acq_fgr] <= head;
    end
  end
endmodule

// File: rtl/issue_rat_freelist_mp.sv
// Multi-port PRF free list with per-FGR rollback checkpoints.
// Optional ISSUE_RAT_FREELIST_MP_COUNT_EN adds registered o_free_count / o_almost_empty.
module issue_rat_freelist_mp #(
  parameter int unsigned PRF_COUNT  = 64,
  parameter int unsigned PRF_W      = issue_pkg::PRF_W,
  parameter int unsigned ARCH_COUNT = issue_pkg::ARCH_COUNT,
  parameter int unsigned ACQ_PORTS  = 2,
  parameter int unsigned RED_PORTS  = 2,
  parameter int unsigned FGR_COUNT  = 8,
  parameter int unsigned FGR_W      = issue_pkg::FGR_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [RED_PORTS*PRF_W-1:0] i_redeemed_prf,
  input  logic [RED_PORTS-1:0]       i_redeemed_valid,
  output logic                       o_redeemed_ready,
  output logic [ACQ_PORTS*PRF_W-1:0] o_acquire_prf,
  output logic [ACQ_PORTS-1:0]       o_acquire_valid,
  input  logic [FGR_W-1:0]           i_acquire_fgr,
  input  logic                       i_acquire_fgr_speculative,
  input  logic [ACQ_PORTS-1:0]       i_acquire_ready,
  input  logic [FGR_W-1:0]           i_commit_fgr,
  input  logic                       i_commit_valid,
  input  logic [FGR_W-1:0]           i_abandon_fgr,
  input  logic                       i_abandon_valid
`ifdef ISSUE_RAT_FREELIST_MP_COUNT_EN
  ,
  output logic [PRF_W:0]             o_free_count,
  output logic [0:0]                 o_almost_empty
`endif
);
  logic [PRF_W-1:0] entry [PRF_COUNT];
  logic [PRF_W:0]   head, tail, free;
  logic [PRF_W:0]   consume, redeem_cnt;
  logic [PRF_W:0]   oldest_ptr, restore_ptr;
  logic             restore_valid;
  logic             run;
  logic [PRF_W+1:0] red_need;
  logic [RED_PORTS-1:0] wr_en;
  logic [PRF_W-1:0]     wr_addr [RED_PORTS];
  logic [ACQ_PORTS-1:0] ready_inc;

  assign free = tail - head;

  always_comb begin
    for (int unsigned k = 0; k < ACQ_PORTS; k++) begin
      o_acquire_valid[k] = reset && !i_abandon_valid && (free > (PRF_W+1)'(k));
      o_acquire_prf[k*PRF_W +: PRF_W] = entry[PRF_W'(head + (PRF_W+1)'(k))];
    end
  end

  // Only the leading run of valid&ready lanes is consumed; a gap stops it.
  always_comb begin
    consume = '0;
    run     = 1'b1;
    for (int unsigned k = 0; k < ACQ_PORTS; k++) begin
      run = run && o_acquire_valid[k] && i_acquire_ready[k];
      if (run)
        consume = consume + 1'b1;
    end
  end

  assign red_need         = {1'b0, tail - oldest_ptr} + (PRF_W+2)'(RED_PORTS);
  assign o_redeemed_ready = reset && (red_need <= (PRF_W+2)'(PRF_COUNT));

  always_comb begin
    redeem_cnt = '0;
    for (int unsigned k = 0; k < RED_PORTS; k++) begin
      wr_en[k]   = i_redeemed_valid[k] && o_redeemed_ready;
      wr_addr[k] = PRF_W'(tail + redeem_cnt);
      if (wr_en[k])
        redeem_cnt = redeem_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= (PRF_W+1)'(PRF_COUNT - ARCH_COUNT);
      for (int unsigned i = 0; i < PRF_COUNT; i++)
        entry[i] <= (i < PRF_COUNT - ARCH_COUNT) ? PRF_W'(ARCH_COUNT + i) : '0;
    end else begin
      head <= restore_valid ? restore_ptr : head + consume;
      tail <= tail + redeem_cnt;
      for (int unsigned k = 0; k < RED_PORTS; k++)
        if (wr_en[k])
          entry[wr_addr[k]] <= i_redeemed_prf[k*PRF_W +: PRF_W];
    end
  end

  issue_rat_freelist_ckpt #(
    .PRF_W    (PRF_W),
    .FGR_COUNT(FGR_COUNT),
    .FGR_W    (FGR_W)
  ) u_ckpt (
    .clk          (clk),
    .reset        (reset),
    .head         (head),
    .acq_fire     (consume != '0),
    .acq_spec     (i_acquire_fgr_speculative),
    .acq_fgr      (i_acquire_fgr),
    .commit_valid (i_commit_valid),
    .commit_fgr   (i_commit_fgr),
    .abandon_valid(i_abandon_valid),
    .abandon_fgr  (i_abandon_fgr),
    .restore_valid(restore_valid),
    .restore_ptr  (restore_ptr),
    .oldest_ptr   (oldest_ptr)
  );

  // A ready vector is a legal prefix exactly when it has the form 0..01..1.
  assign ready_inc = i_acquire_ready + 1'b1;
  assert property (@(posedge clk) disable iff (!reset) ((ready_inc & i_acquire_ready) == '0))
    else $warning("acquire ready is not a lane prefix: %b", i_acquire_ready);

`ifdef ISSUE_RAT_FREELIST_MP_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_free_count   <= (PRF_W+1)'(PRF_COUNT - ARCH_COUNT);
      o_almost_empty <= 1'((PRF_COUNT - ARCH_COUNT) < ACQ_PORTS);
    end else begin
      o_free_count   <= free;
      o_almost_empty <= 1'(free < (PRF_W+1)'(ACQ_PORTS));
    end
  end
`endif
endmodule
